// File: rtl/imem_pkg.sv
// imem_pkg -- shared definitions for the instruction-memory loader controller.
//   IMEM_DEPTH / IMEM_AW / IMEM_DW : default RAM geometry (words, address bits, word bits)
//   state_t                        : controller FSM state encoding
package imem_pkg;

   localparam int IMEM_DEPTH = 64;
   localparam int IMEM_AW    = 6;
   localparam int IMEM_DW    = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_LOAD  = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

endpackage

// File: rtl/imem_loader_ctrl_addr_counter.sv
// addr_counter -- AW-bit clearable incrementing address counter.
//   clk, reset : clock, synchronous active-high reset
//   i_clr      : synchronous clear to zero (wins over i_inc)
//   i_inc      : advance the count by one
//   o_cnt      : current count
//   o_tc       : count equals LAST (terminal address)
module addr_counter #(
   parameter int              AW   = 6,
   parameter logic [AW-1:0]   LAST = '1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_clr,
   input  logic          i_inc,
   output logic [AW-1:0] o_cnt,
   output logic          o_tc
);

   logic [AW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + AW'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl -- owns the port of an external single-port instruction RAM.
// A load request zeroes the whole RAM, then streams loader words into consecutive
// addresses; afterwards the CPU fetches through the same port with no added latency.
//   clk, reset                       : clock, synchronous active-high reset
//   ld_start                         : (re)load request, honoured in IDLE and RUN
//   ld_valid / ld_data / ld_last     : loader word stream
//   ld_ready                         : word accepted this cycle when ld_valid is high
//   ld_done                          : one-cycle pulse after the final word is written
//   ld_count                         : words accepted by the current/last load
//   cpu_addr / cpu_rd / cpu_stall    : CPU fetch port (data valid only in RUN)
//   mem_a / mem_we / mem_wd / mem_rd : external RAM port (combinational read)
module imem_loader_ctrl
   import imem_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH,
   parameter int AW    = IMEM_AW,
   parameter int DW    = IMEM_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   output logic          ld_done,
   output logic [AW:0]   ld_count,
   input  logic [AW-1:0] cpu_addr,
   output logic [DW-1:0] cpu_rd,
   output logic          cpu_stall,
   output logic [AW-1:0] mem_a,
   output logic          mem_we,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t        r_state;
   state_t        w_state_next;
   logic [AW:0]   r_count;
   logic          r_done;
   logic          w_accept;
   logic [AW-1:0] w_clr_cnt;
   logic          w_clr_tc;
   logic [AW-1:0] w_ptr;
   logic          w_ptr_tc;

   // Both counters sit at zero whenever their phase is inactive, so each phase
   // always starts from address 0 without an explicit load.
   addr_counter #(.AW(AW), .LAST(LAST_ADDR)) u_clr_cnt (
      .clk   (clk),
      .reset (reset),
      .i_clr (r_state != ST_CLEAR),
      .i_inc (r_state == ST_CLEAR),
      .o_cnt (w_clr_cnt),
      .o_tc  (w_clr_tc)
   );

   addr_counter #(.AW(AW), .LAST(LAST_ADDR)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .i_clr (r_state != ST_LOAD),
      .i_inc (w_accept),
      .o_cnt (w_ptr),
      .o_tc  (w_ptr_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // Final accept: either the loader flagged it or the RAM is full.
         r_done  <= w_accept && (ld_last || w_ptr_tc);
         // Count is zeroed on CLEAR entry so it holds through RUN/IDLE until reload.
         if ((r_state != ST_CLEAR) && (w_state_next == ST_CLEAR)) begin
            r_count <= '0;
         end else if (w_accept) begin
            r_count <= r_count + (AW + 1)'(1);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      ld_ready     = 1'b0;
      mem_we       = 1'b0;
      mem_a        = '0;
      mem_wd       = '0;
      cpu_rd       = '0;
      cpu_stall    = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (ld_start) w_state_next = ST_CLEAR;
         end
         ST_CLEAR: begin
            mem_we = 1'b1;
            mem_a  = w_clr_cnt;
            if (w_clr_tc) w_state_next = ST_LOAD;
         end
         ST_LOAD: begin
            ld_ready = 1'b1;
            w_accept = ld_valid;
            if (ld_valid) begin
               mem_we = 1'b1;
               mem_a  = w_ptr;
               mem_wd = ld_data;
               if (ld_last || w_ptr_tc) w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            mem_a     = cpu_addr;
            cpu_rd    = mem_rd;
            cpu_stall = 1'b0;
            if (ld_start) w_state_next = ST_CLEAR;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign ld_done  = r_done;
   assign ld_count = r_count;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb_imem_loader_ctrl -- self-checking bench for imem_loader_ctrl with a behavioural
// RAM and an expected-image model derived from the load rules.
module tb_imem_loader_ctrl;
   import imem_pkg::*;

   localparam int D  = IMEM_DEPTH;
   localparam int AW = IMEM_AW;
   localparam int DW = IMEM_DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          ld_start;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_last;
   logic          ld_ready;
   logic          ld_done;
   logic [AW:0]   ld_count;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_rd;
   logic          cpu_stall;
   logic [AW-1:0] mem_a;
   logic          mem_we;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] ram     [D];
   logic [DW-1:0] exp_img [D];
   logic [DW-1:0] words   [D];

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] rd;
   } vec_t;
   vec_t tbl[5];

   always #5 clk = ~clk;

   imem_loader_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .ld_start  (ld_start),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_last   (ld_last),
      .ld_ready  (ld_ready),
      .ld_done   (ld_done),
      .ld_count  (ld_count),
      .cpu_addr  (cpu_addr),
      .cpu_rd    (cpu_rd),
      .cpu_stall (cpu_stall),
      .mem_a     (mem_a),
      .mem_we    (mem_we),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd)
   );

   always @(posedge clk) begin
      if (mem_we === 1'b1) ram[mem_a] <= mem_wd;
   end
   always_comb mem_rd = ram[mem_a];

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Entry: posedge+1 in IDLE or RUN. Exit: posedge+1 inside LOAD.
   task automatic do_clear(input bit from_run);
      int good;
      int nz;
      ld_start = 1'b1; ld_valid = 1'b1; ld_last = 1'b1; ld_data = '1;
      #1;
      if (from_run) check("stall_low_on_start_cycle", cpu_stall, 0);
      cyc();
      check("stall_on_clear_entry", cpu_stall, 1);
      check("count_zero_on_clear", ld_count, 0);
      good = 0;
      for (int i = 0; i < D; i++) begin
         ld_start = 1'($urandom % 2);   // must be ignored while clearing
         #1;
         if (mem_we && mem_wd == '0 && mem_a == AW'(i) && !ld_ready && cpu_stall
             && cpu_rd == '0 && !ld_done) good++;
         cyc();
      end
      ld_start = 1'b0; ld_valid = 1'b0;
      #1;
      check("clear_cycles_ok", good, D);
      check("ready_after_clear", ld_ready, 1);
      check("no_write_idle_load", mem_we, 0);
      nz = 0;
      for (int i = 0; i < D; i++) begin
         if (ram[i] != '0) nz++;
         exp_img[i] = '0;
      end
      check("ram_zeroed", nz, 0);
      $display("clear: from_run=%0d cycles_ok=%0d nonzero=%0d", from_run, good, nz);
      cyc();
   endtask

   // Entry: posedge+1 in LOAD. mode 0 = always valid, 1 = toggle, 2 = random.
   task automatic do_load(input int mode, input int last_idx, input int n_exp);
      int idx;
      int bad;
      int c;
      bit v;
      bit fin;
      idx = 0; bad = 0; c = 0; fin = 0;
      while (!fin && c < 600) begin
         v = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 2) == 0) : 1'($urandom % 2);
         ld_valid = v;
         ld_data  = v ? words[idx] : DW'($urandom);
         ld_last  = v ? (idx == last_idx) : 1'($urandom % 2);
         ld_start = (mode == 2) ? ($urandom % 4 == 0) : 1'b0;
         #1;
         if (!ld_ready || !cpu_stall || ld_done || cpu_rd != '0) bad++;
         if (v) begin
            if (!mem_we || mem_a != AW'(idx) || mem_wd != words[idx]) bad++;
            exp_img[idx] = words[idx];
            if (idx == last_idx || idx == D - 1) fin = 1;
            idx++;
         end else if (mem_we) begin
            bad++;
         end
         cyc();
         c++;
      end
      ld_valid = 1'b0; ld_start = 1'b0; ld_last = 1'b0;
      #1;
      check("load_finished_in_budget", fin, 1);
      check("load_cycle_errors", bad, 0);
      check("ld_done_pulse", ld_done, 1);
      check("run_stall_low", cpu_stall, 0);
      check("run_ready_low", ld_ready, 0);
      check("ld_count_final", ld_count, n_exp);
      $display("load: mode=%0d last_idx=%0d words=%0d ld_count=%0d", mode, last_idx, idx, ld_count);
      cyc();
      #1;
      check("ld_done_one_cycle", ld_done, 0);
      check("ld_count_hold", ld_count, n_exp);
      cyc();
   endtask

   task automatic read_all();
      int bad;
      bad = 0;
      for (int a = 0; a < D; a++) begin
         cpu_addr = AW'(a);
         #1;
         if (cpu_rd != exp_img[a] || cpu_stall || mem_we) bad++;
         cyc();
      end
      check("run_read_image", bad, 0);
      $display("read_all: mismatches=%0d", bad);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nbad;
      int last_idx;
      tbl[0] = '{addr: 6'd0,  rd: 32'h2008_0005};
      tbl[1] = '{addr: 6'd1,  rd: 32'h2009_0007};
      tbl[2] = '{addr: 6'd2,  rd: 32'h0109_5020};
      tbl[3] = '{addr: 6'd3,  rd: 32'h0000_0000};
      tbl[4] = '{addr: 6'd63, rd: 32'h0000_0000};
      for (int i = 0; i < D; i++) ram[i] = 32'hDEAD_0000 | DW'(i);

      // Reset wins over simultaneous ld_start / ld_valid.
      reset = 1'b1; ld_start = 1'b1; ld_valid = 1'b1; ld_data = '1; ld_last = 1'b1;
      cpu_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", cpu_stall, 1);
      check("rst_ready", ld_ready, 0);
      check("rst_we", mem_we, 0);
      check("rst_cpu_rd", cpu_rd, 0);
      check("rst_count", ld_count, 0);
      check("rst_done", ld_done, 0);
      cyc();
      reset = 1'b0; ld_start = 1'b0; ld_valid = 1'b1; ld_last = 1'b0;
      #1;
      check("idle_valid_ignored", mem_we, 0);
      check("idle_stall", cpu_stall, 1);
      cyc();
      check("ram_untouched_idle", ram[5], 32'hDEAD_0005);

      // Clear then three-word program.
      do_clear(0);
      words[0] = 32'h2008_0005; words[1] = 32'h2009_0007; words[2] = 32'h0109_5020;
      do_load(0, 2, 3);
      for (int i = 0; i < 5; i++) begin
         cpu_addr = tbl[i].addr;
         #1;
         check($sformatf("tbl_read_addr%0d", tbl[i].addr), cpu_rd, tbl[i].rd);
         $display("read: addr=%0d rd=0x%08h", tbl[i].addr, cpu_rd);
         cyc();
      end
      read_all();

      // Reload from RUN, 64 words without ld_last, valid toggling.
      for (int i = 0; i < D; i++) words[i] = 32'h1000_0000 + DW'(i) * 32'h0001_0203;
      do_clear(1);
      do_load(1, -1, 64);
      cpu_addr = 6'd63;
      #1;
      check("full_load_addr63", cpu_rd, 32'h1000_0000 + 32'd63 * 32'h0001_0203);
      cyc();
      read_all();

      // Reload with a single word: everything past it reads zero.
      words[0] = 32'hCAFE_F00D;
      do_clear(1);
      do_load(0, 0, 1);
      cpu_addr = 6'd0;
      #1;
      check("one_word_addr0", cpu_rd, 32'hCAFE_F00D);
      cyc();
      cpu_addr = 6'd1;
      #1;
      check("one_word_addr1_zero", cpu_rd, 0);
      cyc();

      // Randomized loads with random valid gaps, stray ld_start and random end.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < D; i++) words[i] = DW'($urandom);
         last_idx = ($urandom % 3 == 0) ? -1 : int'($urandom_range(0, D - 1));
         do_clear(1);
         do_load(2, last_idx, (last_idx < 0) ? D : last_idx + 1);
         read_all();
      end

      // Reset during CLEAR cycle 10: writes 0..10 happen, then nothing more.
      ld_start = 1'b1;
      #1;
      cyc();
      ld_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         cyc();
      end
      reset = 1'b1;
      #1;
      check("clear_cycle10_addr", mem_a, 10);
      cyc();
      ld_start = 1'b1; ld_valid = 1'b1;
      #1;
      check("abort_we", mem_we, 0);
      check("abort_stall", cpu_stall, 1);
      check("abort_count", ld_count, 0);
      check("abort_ready", ld_ready, 0);
      cyc();
      reset = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
      nbad = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (mem_we || !cpu_stall || ld_done || ld_count != '0) nbad++;
         cyc();
      end
      check("post_abort_idle", nbad, 0);
      for (int i = 0; i <= 10; i++) exp_img[i] = '0;
      nbad = 0;
      for (int i = 0; i < D; i++) if (ram[i] != exp_img[i]) nbad++;
      check("abort_ram_image", nbad, 0);
      $display("abort: ram_mismatches=%0d", nbad);

      // Normal operation resumes after the abort.
      do_clear(0);
      words[0] = 32'h2008_0005; words[1] = 32'h2009_0007; words[2] = 32'h0109_5020;
      do_load(0, 2, 3);
      read_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader_ctrl.md
IMEM_LOADER_CTRL -- requirements
Module: imem_loader_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of instruction words in the shared RAM.
REQ-002 SHALL have parameter AW, default 6, word-address width (log2 DEPTH).
REQ-003 SHALL have parameter DW, default 32, instruction word width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ld_start  input  1  request to (re)load the program: clear RAM, then accept words.
REQ-007 SHALL have port ld_valid  input  1  loader word present on ld_data.
REQ-008 SHALL have port ld_data  input  DW  program word, written at the next sequential address.
REQ-009 SHALL have port ld_last  input  1  qualifies ld_valid; this word ends the program.
REQ-010 SHALL have port ld_ready  output  1  controller accepts a loader word this cycle.
REQ-011 SHALL have port ld_done  output  1  one-cycle pulse when the load completes.
REQ-012 SHALL have port ld_count  output  AW+1  words accepted in the current/last load.
REQ-013 SHALL have port cpu_addr  input  AW  CPU fetch word address.
REQ-014 SHALL have port cpu_rd  output  DW  fetched instruction.
REQ-015 SHALL have port cpu_stall  output  1  fetch data invalid; CPU holds its PC.
REQ-016 SHALL have ports mem_a (output AW), mem_we (output 1), mem_wd (output DW), mem_rd (input DW): single-port RAM, combinational read, write on clk edge when mem_we.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, LOAD, RUN.
REQ-018 IDLE: cpu_stall=1, ld_ready=0, mem_we=0; ld_start -> CLEAR with clear counter 0.
REQ-019 CLEAR: mem_we=1, mem_wd=0, mem_a=clear counter; counter increments each cycle; after writing address DEPTH-1 (exactly DEPTH cycles) -> LOAD with write pointer 0 and ld_count 0.
REQ-020 LOAD: ld_ready=1; a word is accepted when ld_valid&&ld_ready; on accept mem_we=1, mem_a=write pointer, mem_wd=ld_data, pointer and ld_count increment.
REQ-021 LOAD SHALL end (-> RUN, ld_done=1 for the following cycle) on accept with ld_last=1, or on accept at address DEPTH-1 regardless of ld_last; remaining addresses stay zero.
REQ-022 ld_valid with ld_last=1 at pointer 0 SHALL produce ld_count=1; ld_count SHALL reach DEPTH (64) on full load without wrap.
REQ-023 RUN: mem_a=cpu_addr, cpu_rd=mem_rd (zero added latency), cpu_stall=0, mem_we=0, ld_ready=0.
REQ-024 cpu_rd SHALL be 0 and cpu_stall 1 in every state except RUN.
REQ-025 ld_start in RUN SHALL -> CLEAR next cycle (reload); cpu_stall rises that same next cycle.
REQ-026 ld_start in CLEAR or LOAD SHALL be ignored; ld_valid outside LOAD SHALL be ignored and write nothing.
REQ-027 ld_count SHALL hold its final value through RUN and IDLE until the next CLEAR entry.
REQ-028 ld_done SHALL never assert outside the cycle after LOAD completion.

Reset
REQ-029 reset SHALL force IDLE, clear counter 0, write pointer 0, ld_count 0, ld_done 0; outputs immediately follow IDLE rules (cpu_stall=1, ld_ready=0, mem_we=0, cpu_rd=0).
REQ-030 reset mid-CLEAR or mid-LOAD SHALL abort with no further RAM writes; RAM contents are left as-is.
REQ-031 reset SHALL take priority over ld_start and ld_valid in the same cycle.

Structure
REQ-032 State encoding and DEPTH/AW/DW defaults SHALL live in shared package imem_pkg, used by the RAM and bench.
REQ-033 SHALL contain one sub-module, addr_counter (AW-bit clearable incrementing counter with terminal-count flag), instantiated for clear counter and write pointer.
REQ-034 RAM SHALL remain external; controller holds no array storage.

Verification
REQ-035 reset, ld_start pulse -> exactly 64 cycles of mem_we with mem_wd=0, mem_a 0..63, then ld_ready=1.
REQ-036 load 3 words 0x20080005, 0x20090007, 0x01095020 (last on third) -> ld_done pulse, ld_count=3, RUN; cpu_addr=2 gives cpu_rd=0x01095020, cpu_addr=3 gives 0.
REQ-037 ld_valid toggled 1/0 per cycle during LOAD -> only valid cycles write; addresses contiguous.
REQ-038 64 words without ld_last -> RUN after 64th accept, ld_count=64, cpu_addr=63 returns 64th word.
REQ-039 ld_start while RUN -> cpu_stall=1 next cycle, RAM re-zeroed; second 1-word load -> cpu_addr=1 reads 0.
REQ-040 reset asserted at CLEAR cycle 10 -> IDLE, no mem_we after reset edge, ld_count=0.
